// File: rtl/theta_sweep_gen.sv
// Streaming generator of the normalised mirror-angle ramp theta(k) = 1 - 2k/(N-1).
// Produces one point per clock using STEP accumulation, with sawtooth/triangle multi-sweep runs and valid/ready output.
module theta_sweep_gen #(
    parameter int INT_W_P   = 2,
    parameter int FRAC_W_P  = 32,
    parameter int COLUMNS_P = 360,
    parameter int FRAMES_P  = 5
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic                               mode_i,
    input  logic [7:0]                         sweeps_i,
    input  logic                               abort_i,
    input  logic                               ready_i,
    output logic                               valid_o,
    output logic signed [INT_W_P+FRAC_W_P-1:0] theta_o,
    output logic [9:0]                         col_o,
    output logic [2:0]                         frame_o,
    output logic                               dir_o,
    output logic                               sweep_last_o,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam int     W      = INT_W_P + FRAC_W_P;
    localparam int     AW     = W + 1;
    localparam longint N_L    = longint'(COLUMNS_P) * longint'(FRAMES_P);
    localparam longint ONE_L  = longint'(1) <<< FRAC_W_P;
    localparam longint STEP_L = (2 * ONE_L + (N_L - 1) / 2) / (N_L - 1);

    localparam logic signed [AW-1:0] ONE_A   = AW'(ONE_L);
    localparam logic signed [AW-1:0] STEP_A  = AW'(STEP_L);
    localparam logic [9:0]           COL_LAST = 10'(COLUMNS_P - 1);
    localparam logic [9:0]           COL_PEN  = 10'(COLUMNS_P - 2);
    localparam logic [2:0]           FRM_LAST = 3'(FRAMES_P - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e                state_q, state_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [9:0]            col_q, col_d;
    logic [2:0]            frame_q, frame_d;
    logic                  dir_q, dir_d;
    logic                  mode_q, mode_d;
    logic [7:0]            sweeps_q, sweeps_d;
    logic [7:0]            sweep_cnt_q, sweep_cnt_d;
    logic                  done_q, done_d;

    logic hs, last, next_is_last, end_run, run_over;

    assign hs           = (state_q == RUN) && ready_i;
    assign last         = (col_q == COL_LAST) && (frame_q == FRM_LAST);
    assign next_is_last = (col_q == COL_PEN) && (frame_q == FRM_LAST);
    assign end_run      = (sweeps_q != 8'd0) &&
                          (({1'b0, sweep_cnt_q} + 9'd1) == {1'b0, sweeps_q});
    assign run_over     = hs && last && end_run;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = RUN;
            RUN:  if (abort_i || run_over) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d       = acc_q;
        col_d       = col_q;
        frame_d     = frame_q;
        dir_d       = dir_q;
        mode_d      = mode_q;
        sweeps_d    = sweeps_q;
        sweep_cnt_d = sweep_cnt_q;
        done_d      = 1'b0;
        if (state_q == IDLE) begin
            if (start_i) begin
                mode_d      = mode_i;
                sweeps_d    = sweeps_i;
                acc_d       = ONE_A;
                col_d       = 10'd0;
                frame_d     = 3'd0;
                dir_d       = 1'b0;
                sweep_cnt_d = 8'd0;
            end
        end else if (abort_i || run_over) begin
            // Leaving RUN parks the datapath at its reset values.
            acc_d   = '0;
            col_d   = 10'd0;
            frame_d = 3'd0;
            dir_d   = 1'b0;
            done_d  = !abort_i;
        end else if (hs) begin
            if (last) begin
                sweep_cnt_d = sweep_cnt_q + 8'd1;
                col_d       = 10'd0;
                frame_d     = 3'd0;
                if (mode_q) begin
                    dir_d = ~dir_q;
                end else begin
                    dir_d = 1'b0;
                    acc_d = ONE_A;
                end
            end else begin
                if (col_q == COL_LAST) begin
                    col_d   = 10'd0;
                    frame_d = frame_q + 3'd1;
                end else begin
                    col_d = col_q + 10'd1;
                end
                // Final point is snapped to the exact endpoint to cancel rounding drift.
                if (next_is_last) begin
                    acc_d = dir_q ? ONE_A : -ONE_A;
                end else begin
                    acc_d = dir_q ? (acc_q + STEP_A) : (acc_q - STEP_A);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q       <= '0;
            col_q       <= 10'd0;
            frame_q     <= 3'd0;
            dir_q       <= 1'b0;
            mode_q      <= 1'b0;
            sweeps_q    <= 8'd0;
            sweep_cnt_q <= 8'd0;
            done_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            col_q       <= col_d;
            frame_q     <= frame_d;
            dir_q       <= dir_d;
            mode_q      <= mode_d;
            sweeps_q    <= sweeps_d;
            sweep_cnt_q <= sweep_cnt_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        valid_o      = (state_q == RUN);
        busy_o       = (state_q == RUN);
        sweep_last_o = (state_q == RUN) && last;
        col_o        = col_q;
        frame_o      = frame_q;
        dir_o        = dir_q;
        done_o       = done_q;
        // Accumulator headroom bit never differs from the sign in range; clamp defensively.
        if (acc_q[AW-1] != acc_q[W-1]) begin
            theta_o = acc_q[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            theta_o = acc_q[W-1:0];
        end
    end

endmodule

// File: tb/tb_theta_sweep_gen.sv
// Directed bench for theta_sweep_gen: a small 4-point configuration and the default 1800-point one.
module tb_theta_sweep_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Small configuration: FRAC 16, 4 columns, 1 frame.
    logic               s_start = 0, s_mode = 0, s_abort = 0, s_ready = 0;
    logic [7:0]         s_sweeps = 0;
    logic               s_valid, s_dir, s_last, s_busy, s_done;
    logic signed [17:0] s_theta;
    logic [9:0]         s_col;
    logic [2:0]         s_frame;

    // Default configuration: FRAC 32, 360 columns, 5 frames.
    logic               b_start = 0, b_mode = 0, b_abort = 0, b_ready = 0;
    logic [7:0]         b_sweeps = 0;
    logic               b_valid, b_dir, b_last, b_busy, b_done;
    logic signed [33:0] b_theta;
    logic [9:0]         b_col;
    logic [2:0]         b_frame;

    theta_sweep_gen #(.INT_W_P(2), .FRAC_W_P(16), .COLUMNS_P(4), .FRAMES_P(1)) u_small (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .mode_i(s_mode), .sweeps_i(s_sweeps),
        .abort_i(s_abort), .ready_i(s_ready), .valid_o(s_valid), .theta_o(s_theta),
        .col_o(s_col), .frame_o(s_frame), .dir_o(s_dir), .sweep_last_o(s_last),
        .busy_o(s_busy), .done_o(s_done)
    );

    theta_sweep_gen u_big (
        .clk_i(clk), .rst_i(rst), .start_i(b_start), .mode_i(b_mode), .sweeps_i(b_sweeps),
        .abort_i(b_abort), .ready_i(b_ready), .valid_o(b_valid), .theta_o(b_theta),
        .col_o(b_col), .frame_o(b_frame), .dir_o(b_dir), .sweep_last_o(b_last),
        .busy_o(b_busy), .done_o(b_done)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    longint desc [4] = '{65536, 21845, -21846, -65536};
    longint asc  [4] = '{-65536, -21845, 21846, 65536};
    bit     pat  [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0};

    task automatic check_small_idle(input string tag);
        check({tag, "_valid"}, s_valid, 0);
        check({tag, "_busy"},  s_busy, 0);
        check({tag, "_done"},  s_done, 0);
        check({tag, "_last"},  s_last, 0);
        check({tag, "_dir"},   s_dir, 0);
        check({tag, "_theta"}, s_theta, 0);
        check({tag, "_col"},   s_col, 0);
        check({tag, "_frame"}, s_frame, 0);
    endtask

    task automatic start_small(input logic mode, input logic [7:0] sw, input logic rdy);
        @(negedge clk);
        s_start = 1; s_mode = mode; s_sweeps = sw; s_ready = rdy;
        @(negedge clk);
        s_start = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        longint one_b, ideal_s, err, max_err;
        int     idx, c;
        bit     done_seen, valid_drop;

        // Reset state
        repeat (3) @(negedge clk);
        check_small_idle("rst_s");
        check("rst_b_valid", b_valid, 0);
        check("rst_b_theta", b_theta, 0);
        check("rst_b_busy", b_busy, 0);
        rst = 0;

        // Test 1: sawtooth, one sweep
        start_small(0, 8'd1, 1);
        check("t1_busy", s_busy, 1);
        for (int i = 0; i < 4; i++) begin
            check("t1_valid", s_valid, 1);
            check("t1_theta", s_theta, desc[i]);
            check("t1_col", s_col, i);
            check("t1_last", s_last, longint'(i == 3));
            check("t1_dir", s_dir, 0);
            @(negedge clk);
        end
        check("t1_valid_off", s_valid, 0);
        check("t1_done", s_done, 1);
        @(negedge clk);
        check("t1_done_pulse", s_done, 0);

        // Test 2: triangle, two sweeps
        start_small(1, 8'd2, 1);
        for (int i = 0; i < 8; i++) begin
            check("t2_theta", s_theta, (i < 4) ? desc[i] : asc[i-4]);
            check("t2_dir", s_dir, longint'(i >= 4));
            check("t2_col", s_col, i % 4);
            check("t2_last", s_last, longint'((i % 4) == 3));
            check("t2_done_early", s_done, 0);
            @(negedge clk);
        end
        check("t2_done", s_done, 1);
        check("t2_valid_off", s_valid, 0);
        @(negedge clk);
        check("t2_done_pulse", s_done, 0);

        // Test 3: back-pressure
        start_small(0, 8'd1, 0);
        idx = 0; c = 0;
        while (idx < 4 && c < 40) begin
            check("t3_valid", s_valid, 1);
            check("t3_theta", s_theta, desc[idx]);
            check("t3_col", s_col, idx);
            s_ready = pat[c % 12];
            @(negedge clk);
            if (pat[c % 12]) idx++;
            c++;
        end
        check("t3_points_accepted", idx, 4);
        check("t3_done", s_done, 1);
        check("t3_valid_off", s_valid, 0);
        s_ready = 1;

        // Test 5: start while busy is ignored, then reset mid-run
        start_small(0, 8'd1, 1);
        check("t5_p0", s_theta, desc[0]);
        s_start = 1;
        @(negedge clk);
        s_start = 0;
        check("t5_no_restart", s_theta, desc[1]);
        check("t5_no_restart_col", s_col, 1);
        @(negedge clk);
        check("t5_p2", s_theta, desc[2]);
        rst = 1;
        @(negedge clk);
        check_small_idle("t5_rst");
        rst = 0;
        @(negedge clk);
        check("t5_stays_idle", s_valid, 0);

        // Test 7: start beats abort in IDLE; abort wins over handshake in RUN
        @(negedge clk);
        s_start = 1; s_abort = 1; s_mode = 0; s_sweeps = 8'd1;
        @(negedge clk);
        s_start = 0; s_abort = 0;
        check("t7_start_wins", s_valid, 1);
        check("t7_theta", s_theta, desc[0]);
        s_abort = 1;
        @(negedge clk);
        s_abort = 0;
        check("t7_abort_valid", s_valid, 0);
        check("t7_abort_done", s_done, 0);
        check("t7_abort_busy", s_busy, 0);

        // Tests 4 and 6: default params, continuous, abort at 2000th handshake
        one_b = longint'(1) << 32;
        max_err = 0; done_seen = 0; valid_drop = 0;
        @(negedge clk);
        b_start = 1; b_mode = 0; b_sweeps = 8'd0; b_ready = 1;
        @(negedge clk);
        b_start = 0;
        for (int p = 0; p < 2000; p++) begin
            if (p < 1800) begin
                ideal_s = one_b * 1799 - longint'(p) * 2 * one_b;
                err = longint'(b_theta) * 1799 - ideal_s;
                if (err < 0) err = -err;
                if (err > max_err) max_err = err;
            end
            if (p == 0)    check("t6_first", b_theta, one_b);
            if (p == 360)  check("t4_frame1", b_frame, 1);
            if (p == 1799) begin
                check("t6_last_exact", b_theta, -one_b);
                check("t4_last_frame", b_frame, 4);
                check("t4_last_col", b_col, 359);
                check("t4_last_flag", b_last, 1);
            end
            if (p == 1800) begin
                check("t4_wrap_frame", b_frame, 0);
                check("t4_wrap_col", b_col, 0);
                check("t4_wrap_theta", b_theta, one_b);
                check("t4_wrap_dir", b_dir, 0);
            end
            if (b_done)   done_seen = 1;
            if (!b_valid) valid_drop = 1;
            if (p == 1999) b_abort = 1;
            @(negedge clk);
        end
        b_abort = 0;
        check("t4_abort_valid", b_valid, 0);
        check("t4_abort_done", b_done, 0);
        check("t4_abort_busy", b_busy, 0);
        check("t4_done_never", done_seen, 0);
        check("t4_valid_steady", valid_drop, 0);
        check("t6_err_within_1800lsb", (max_err <= longint'(1800) * 1799) ? 1 : 0, 1);
        @(negedge clk);
        check("t4_done_after", b_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
